uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit stage that sits downstream of the oversample tick counter.
//  Consumes the counter's one-cycle tick_16x enable and serializes a parallel
//  byte onto the tx line: 8N1 by default, LSB first, idle high.
//  Provides a valid/ready byte interface for the UART controller's TX path.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..8)
//  OVERSAMPLE  16  ticks per bit period; internal oversample counter width = clog2
//  STOP_BITS   1   stop bits per frame (1 or 2)
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  tick_16x   in   1          one-clk pulse at OVERSAMPLE x baud, from tick counter
//  tx_data    in   DATA_BITS  byte to send; sampled only on accept
//  tx_valid   in   1          tx_data valid
//  tx_ready   out  1          high only in IDLE; accept = tx_valid & tx_ready
//  tx         out  1          serial line; 1 = idle/mark
//  tx_busy    out  1          high from the cycle after accept until the frame ends
//  tx_done    out  1          one-clk pulse when the last stop bit completes
// BEHAVIOUR
//  Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, os_cnt=0.
//  Reset is async: asserting reset mid-frame aborts the frame and drives tx=1 at once.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: tx=1. On accept, latch tx_data into shift_reg, clear os_cnt and bit_cnt,
//   and go to START. tx falls low the next clk.
//  tick_16x on the accept cycle is ignored; counting starts the following clk.
//  Each bit lasts exactly OVERSAMPLE ticks. os_cnt increments on tick_16x only.
//  A bit ends on the clk where tick_16x=1 and os_cnt==OVERSAMPLE-1; os_cnt wraps to 0.
//  START: tx=0 for one bit period, then go to DATA.
//  DATA: tx=shift_reg[0]; shift right at each bit end. After DATA_BITS bits, go to
//   PARITY if enabled, otherwise STOP.
//  STOP: tx=1 for STOP_BITS bit periods. At the final bit end:
//   tx_done=1 for that clk only, state returns to IDLE, tx_ready=1 on the next clk.
//  Frame length = (1+DATA_BITS+P+STOP_BITS)*OVERSAMPLE ticks, where P = 1 with parity, else 0.
//  tx_valid while not IDLE: ignored; no queuing. tx_data changes after accept: no effect.
//  No tick_16x pulses: FSM holds state; tx holds its current value indefinitely.
//  Outputs tx, tx_ready, tx_busy and tx_done are registered (no combinational paths from inputs).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: adds a PARITY state after DATA.
//   tx = XOR of the latched data bits (even parity), driven for one bit period.
//  UART_TX_PARITY_EN undefined: no PARITY state, no parity logic; DATA goes straight to STOP.
// STRUCTURE
//  uart_pkg: tx_state_t enum (IDLE, START, DATA, PARITY, STOP), UART_IDLE_LVL=1'b1,
//   and DEFAULT_OVERSAMPLE=16. These are shared with the future uart_rx.
//  Sub-module uart_bit_timer: oversample counter.
//   Inputs: tick, clear. Output: bit_end pulse.
//   Reused by uart_rx for mid-bit sampling.
//  All other logic is flat in uart_tx_serializer.
// TESTING
//  1. tick_16x=1 every clk, send 0x55 (no parity):
//     tx=0 for 16 clks, then 1,0,1,0,1,0,1,0 at 16 clks each, then 1.
//     tx_done pulses at clk 160 after accept.
//  2. Back-to-back: hold tx_valid high with 0xA3 then 0x0F.
//     Second accept occurs exactly 1 clk after the first tx_done.
//     No glitch on tx between the stop bit and the next start bit.
//  3. tick_16x every 4th clk, send 0xFF:
//     each bit lasts 64 clks; the frame lasts 640 clks.
//     Pulse tx_valid during the frame: no second accept.
//  4. Assert reset mid-frame (during data bit 3):
//     tx=1, tx_ready=1, tx_busy=0 the same cycle.
//     After release, a fresh 0x3C frame is correct.
//  5. With UART_TX_PARITY_EN, send 0x07: parity bit=1. Send 0x03: parity bit=0.
//     Frame is 176 ticks.
//  6. STOP_BITS=2, DATA_BITS=7, send 0x41: stop high for 32 ticks; tx_done at tick 160.

Source files
------------

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic UART_IDLE_LVL      = 1'b1;
  localparam int   DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample counter: counts tick pulses and flags the tick that closes a bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] os_cnt;

  // clear wins over tick so a tick landing on the clear cycle is not counted
  assign bit_end = tick && !clear && (os_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_cnt <= '0;
    end else if (clear) begin
      os_cnt <= '0;
    end else if (tick) begin
      os_cnt <= bit_end ? '0 : os_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes a byte LSB first onto tx (idle high), 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output tx_state_t            state
);

  // Handshake: a byte transfers on a rising clk where tx_valid and tx_ready are
  // both high. tx_ready is high only in IDLE; tx_valid seen elsewhere is dropped,
  // and tx_data is captured only on the transfer cycle.

  localparam int BCW = $clog2(DATA_BITS + STOP_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] shift_reg;
  logic [BCW-1:0]       bit_cnt;
  logic                 bit_end;
  logic                 timer_clear;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Holding the timer cleared through IDLE makes counting start the clk after accept.
  assign timer_clear = (state == IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick_16x),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= UART_IDLE_LVL;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg <= tx_data;
            bit_cnt   <= '0;
            tx        <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= UART_IDLE_LVL;
              state <= STOP;
`endif
            end else begin
              // next bit is shift_reg[1] because the shift lands on this same edge
              bit_cnt <= bit_cnt + BCW'(1);
              tx      <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= UART_IDLE_LVL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt  <= '0;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              state    <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        default: begin
          tx       <= UART_IDLE_LVL;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: an 8N1 instance and a 7-data/2-stop instance.
module tb_uart_tx_serializer;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_16x;
  logic [7:0] data0;
  logic       valid0, ready0, tx0, busy0, done0;
  tx_state_t  state0;
  logic [6:0] data1;
  logic       valid1, ready1, tx1, busy1, done1;
  tx_state_t  state1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tick_period = 1;
  logic last_tick = 1'b0;

  always #5 clk = ~clk;

  uart_tx_serializer u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .tick_16x (tick_16x),
    .tx_data  (data0),
    .tx_valid (valid0),
    .tx_ready (ready0),
    .tx       (tx0),
    .tx_busy  (busy0),
    .tx_done  (done0),
    .state    (state0)
  );

  uart_tx_serializer #(
    .DATA_BITS (7),
    .STOP_BITS (2)
  ) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .tick_16x (tick_16x),
    .tx_data  (data1),
    .tx_valid (valid1),
    .tx_ready (ready1),
    .tx       (tx1),
    .tx_busy  (busy1),
    .tx_done  (done1),
    .state    (state1)
  );

  // one clock: drive tick for this cycle, take the rising edge, return at the falling edge
  task automatic clk_step();
    tick_16x = (cyc % tick_period == 0);
    @(posedge clk);
    last_tick = tick_16x;
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_valid(input int which, input logic v);
    if (which != 0) valid1 = v;
    else valid0 = v;
  endtask

  task automatic set_data(input int which, input logic [7:0] d);
    if (which != 0) data1 = d[6:0];
    else data0 = d;
  endtask

  // Sends one frame and checks every clk of it against a tick-counting model.
  task automatic run_frame(input int which, input logic [7:0] data, input bit keep_valid,
                           input logic [7:0] next_data, input int poke_at,
                           input string name, output logic [15:0] mid_bits);
    int nb, sb, frame, t, k, bound, mism, first_bad, done_k;
    logic bits [16];
    logic [7:0] d;
    logic exp_tx, exp_busy, exp_done, a_tx, a_busy, a_ready, a_done;
    bit poked, poke_live;
    nb = (which != 0) ? 7 : 8;
    sb = (which != 0) ? 2 : 1;
    d = (which != 0) ? {1'b0, data[6:0]} : data;
    for (int i = 0; i < 16; i++) bits[i] = 1'b1;
    bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) bits[1+i] = d[i];
    if (PAR == 1) bits[1+nb] = ^d;
    frame = (1 + nb + PAR + sb) * 16;
    mid_bits = '0;
    while (cyc % tick_period != 0) clk_step();
    a_ready = (which != 0) ? ready1 : ready0;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, a_ready);
    end
    set_data(which, data);
    set_valid(which, 1'b1);
    clk_step();
    if (keep_valid) begin
      set_data(which, next_data);
    end else begin
      set_valid(which, 1'b0);
      set_data(which, ~data);
    end
    t = 0; k = 0; mism = 0; first_bad = -1; done_k = -1; poked = 0; poke_live = 0;
    bound = frame * tick_period + 64;
    while (1) begin
      a_tx    = (which != 0) ? tx1 : tx0;
      a_busy  = (which != 0) ? busy1 : busy0;
      a_ready = (which != 0) ? ready1 : ready0;
      a_done  = (which != 0) ? done1 : done0;
      if (a_done === 1'b1 && done_k < 0) done_k = k;
      exp_tx   = (t < frame) ? bits[t/16] : 1'b1;
      exp_busy = (t < frame);
      exp_done = (t == frame) && (k > 0);
      if (a_tx !== exp_tx || a_busy !== exp_busy || a_ready !== !exp_busy || a_done !== exp_done) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
      if (k > 0 && last_tick && (t % 16 == 8) && t < frame) mid_bits[t/16] = a_tx;
      if (t >= frame || k >= bound) break;
      if (poke_at >= 0 && t == poke_at && !poked) begin
        set_valid(which, 1'b1);
        poked = 1;
        poke_live = 1;
      end
      clk_step();
      k++;
      if (poke_live) begin
        set_valid(which, 1'b0);
        poke_live = 0;
      end
      if (last_tick) t++;
    end
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL %s waveform: %0d bad clks (first at clk %0d) want 0", name, mism, first_bad);
    end
    total++;
    if (done_k != frame * tick_period) begin
      bad++;
      $display("FAIL %s done_clk: got %0d want %0d", name, done_k, frame * tick_period);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_16x = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) clk_step();
    total++;
    if (tx0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_tx: got %b want 1", tx0);
    end
    total++;
    if (ready0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", ready0);
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy0);
    end
    total++;
    if (done0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done0);
    end
    total++;
    if (state0 !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", state0, IDLE);
    end
    total++;
    if (tx1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_tx1: got %b want 1", tx1);
    end
    reset = 1'b0;
    repeat (2) clk_step();
  endtask

  task automatic test_frame_55();
    logic [15:0] mb;
    tick_period = 1;
    run_frame(0, 8'h55, 0, 8'h00, -1, "frame_55", mb);
    total++;
    if (mb[8:0] !== 9'h0AA) begin
      bad++;
      $display("FAIL frame_55_bits: got %h want 0aa", mb[8:0]);
    end
    clk_step();
    total++;
    if (tx0 !== 1'b1 || ready0 !== 1'b1) begin
      bad++;
      $display("FAIL frame_55_idle: got tx=%b ready=%b want 1 1", tx0, ready0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mb;
    tick_period = 1;
    run_frame(0, 8'hA3, 1, 8'h0F, -1, "b2b_a3", mb);
    total++;
    if (mb[8:0] !== 9'h146) begin
      bad++;
      $display("FAIL b2b_a3_bits: got %h want 146", mb[8:0]);
    end
    total++;
    if (tx0 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap_tx: got %b want 1", tx0);
    end
    run_frame(0, 8'h0F, 0, 8'h00, -1, "b2b_0f", mb);
    total++;
    if (mb[8:0] !== 9'h01E) begin
      bad++;
      $display("FAIL b2b_0f_bits: got %h want 01e", mb[8:0]);
    end
  endtask

  task automatic test_slow_tick();
    logic [15:0] mb;
    int idle_bad;
    tick_period = 4;
    run_frame(0, 8'hFF, 0, 8'h00, 40, "slow_ff", mb);
    total++;
    if (mb[8:0] !== 9'h1FE) begin
      bad++;
      $display("FAIL slow_ff_bits: got %h want 1fe", mb[8:0]);
    end
    idle_bad = 0;
    repeat (20) begin
      clk_step();
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || ready0 !== 1'b1) idle_bad++;
    end
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL slow_no_second_accept: got %0d busy clks want 0", idle_bad);
    end
    tick_period = 1;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] mb;
    tick_period = 1;
    data0 = 8'h96;
    valid0 = 1'b1;
    clk_step();
    valid0 = 1'b0;
    repeat (16 * 4 + 5) clk_step();
    total++;
    if (tx0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_frame_bit3: got %b want 0", tx0);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (tx0 !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_tx: got %b want 1", tx0);
    end
    total++;
    if (ready0 !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_ready: got %b want 1", ready0);
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_busy: got %b want 0", busy0);
    end
    total++;
    if (state0 !== IDLE) begin
      bad++;
      $display("FAIL async_reset_state: got %0d want %0d", state0, IDLE);
    end
    repeat (2) clk_step();
    reset = 1'b0;
    clk_step();
    run_frame(0, 8'h3C, 0, 8'h00, -1, "after_reset_3c", mb);
    total++;
    if (mb[8:0] !== 9'h078) begin
      bad++;
      $display("FAIL after_reset_3c_bits: got %h want 078", mb[8:0]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [15:0] mb;
    tick_period = 1;
    run_frame(0, 8'h07, 0, 8'h00, -1, "parity_07", mb);
    total++;
    if (mb[9] !== 1'b1) begin
      bad++;
      $display("FAIL parity_07_bit: got %b want 1", mb[9]);
    end
    run_frame(0, 8'h03, 0, 8'h00, -1, "parity_03", mb);
    total++;
    if (mb[9] !== 1'b0) begin
      bad++;
      $display("FAIL parity_03_bit: got %b want 0", mb[9]);
    end
  endtask
`endif

  task automatic test_7n2();
    logic [15:0] mb;
    tick_period = 1;
    run_frame(1, 8'h41, 0, 8'h00, -1, "7n2_41", mb);
    total++;
    if (mb[7:0] !== 8'h82) begin
      bad++;
      $display("FAIL 7n2_41_bits: got %h want 82", mb[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_slow_tick();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_7n2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
